// File: rtl/eco_sweep_pkg.sv
// Shared types for the ECO equivalence sweeper: FSM states, sweep sizing and fail-log entry layout.
package eco_sweep_pkg;

   localparam int unsigned W_DEF  = 4;
   localparam int unsigned YW_DEF = 4;
   localparam int unsigned VEC_W  = 2 * W_DEF;
   localparam int unsigned NVEC   = 1 << VEC_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_COMPARE,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [VEC_W-1:0]  vec;
      logic [YW_DEF-1:0] diff;
   } log_entry_t;

endpackage

// File: rtl/eco_fail_fifo.sv
// Fail-log FIFO with a registered head word; compiled only when ECO_FAIL_LOG_EN is defined.
`ifdef ECO_FAIL_LOG_EN
module eco_fail_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d, remain;
   logic          push_ok, pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign rptr_d  = rptr_q + AW'(pop_ok);
   assign remain  = cnt_q - (AW+1)'(pop_ok);
   assign cnt_d   = remain + (AW+1)'(push_ok);

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= data_i;
   end

   // Head word: the surviving entry at the new read pointer, or the pushed
   // word when it lands in an otherwise empty FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         data_o <= '0;
      end else if (clr_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         data_o <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + AW'(1);
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (remain != '0)  data_o <= mem_q[rptr_d];
         else if (push_ok)  data_o <= data_i;
         else               data_o <= '0;
      end
   end

endmodule
`endif

// File: rtl/eco_equiv_sweeper.sv
// Exhaustive (a,b) sweep comparing ECO-patched vs golden netlist outputs.
// Optional fail log enabled by defining ECO_FAIL_LOG_EN.
module eco_equiv_sweeper
   import eco_sweep_pkg::*;
#(
   parameter int unsigned W         = W_DEF,
   parameter int unsigned YW        = YW_DEF,
   parameter int unsigned SETTLE    = 1,
   parameter int unsigned LOG_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [W-1:0]      a_o,
   output logic [W-1:0]      b_o,
   input  logic [YW-1:0]     y_impl_i,
   input  logic [YW-1:0]     y_gold_i,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [2*W:0]      err_cnt,
   output logic [YW-1:0]     diff_mask,
   output logic              first_fail_vld,
   output logic [2*W-1:0]    first_fail_vec,
   input  logic              log_rd,
   output logic              log_vld,
   output logic [2*W+YW-1:0] log_data,
   output logic              log_ovf
);

   localparam int unsigned VW = 2 * W;
   localparam int unsigned CW = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);

   state_e         state_q;
   logic [VW-1:0]  vec_q;
   logic [CW-1:0]  settle_cnt_q;
   logic [W-1:0]   a_q, b_q;
   logic           busy_q, done_q, ffv_q;
   logic [VW:0]    err_cnt_q;
   logic [YW-1:0]  diff_mask_q, diff;
   logic [VW-1:0]  ffvec_q;
   logic           launch, cmp_fire, mismatch;

   assign diff     = y_impl_i ^ y_gold_i;
   assign launch   = (state_q == ST_IDLE || state_q == ST_DONE) && start && !abort;
   assign cmp_fire = (state_q == ST_COMPARE) && !abort;
   assign mismatch = cmp_fire && (diff != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         vec_q        <= '0;
         settle_cnt_q <= '0;
         a_q          <= '0;
         b_q          <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_cnt_q    <= '0;
         diff_mask_q  <= '0;
         ffv_q        <= 1'b0;
         ffvec_q      <= '0;
      end else if (busy_q && abort) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (launch) begin
                  state_q     <= ST_DRIVE;
                  vec_q       <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  err_cnt_q   <= '0;
                  diff_mask_q <= '0;
                  ffv_q       <= 1'b0;
                  ffvec_q     <= '0;
               end
            end
            ST_DRIVE: begin
               a_q          <= vec_q[W-1:0];
               b_q          <= vec_q[VW-1:W];
               settle_cnt_q <= '0;
               state_q      <= (SETTLE > 0) ? ST_SETTLE : ST_COMPARE;
            end
            ST_SETTLE: begin
               if (settle_cnt_q == CW'(SETTLE - 1)) state_q <= ST_COMPARE;
               else settle_cnt_q <= settle_cnt_q + CW'(1);
            end
            ST_COMPARE: begin
               if (mismatch) begin
                  err_cnt_q   <= err_cnt_q + (VW+1)'(1);
                  diff_mask_q <= diff_mask_q | diff;
                  if (!ffv_q) begin
                     ffv_q   <= 1'b1;
                     ffvec_q <= vec_q;
                  end
               end
               if (&vec_q) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  vec_q   <= vec_q + VW'(1);
                  state_q <= ST_DRIVE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign a_o            = a_q;
   assign b_o            = b_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = done_q && (err_cnt_q == '0);
   assign err_cnt        = err_cnt_q;
   assign diff_mask      = diff_mask_q;
   assign first_fail_vld = ffv_q;
   assign first_fail_vec = ffvec_q;

`ifdef ECO_FAIL_LOG_EN
   logic log_full, log_empty, log_ovf_q;

   eco_fail_fifo #(
      .DEPTH (LOG_DEPTH),
      .DW    (VW + YW)
   ) u_fail_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (launch),
      .push_i  (mismatch),
      .data_i  ({vec_q, diff}),
      .pop_i   (log_rd),
      .data_o  (log_data),
      .full_o  (log_full),
      .empty_o (log_empty)
   );

   assign log_vld = !log_empty;

   // A same-cycle pop frees the slot, so only an unpopped full FIFO drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                             log_ovf_q <= 1'b0;
      else if (launch)                                     log_ovf_q <= 1'b0;
      else if (mismatch && log_full && !(log_rd && log_vld)) log_ovf_q <= 1'b1;
   end

   assign log_ovf = log_ovf_q;
`else
   logic log_unused;

   assign log_vld    = 1'b0;
   assign log_data   = '0;
   assign log_ovf    = 1'b0;
   assign log_unused = log_rd | (LOG_DEPTH == 0);
`endif

endmodule

// File: tb/tb_eco_equiv_sweeper.sv
// Randomized self-checking bench for eco_equiv_sweeper against a per-vector mismatch table model.
module tb_eco_equiv_sweeper;
   import eco_sweep_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, abort, log_rd;
   logic [3:0]  a_o, b_o, y_impl, y_gold;
   logic        busy, done, pass, first_fail_vld, log_vld, log_ovf;
   logic [8:0]  err_cnt;
   logic [3:0]  diff_mask;
   logic [7:0]  first_fail_vec;
   logic [11:0] log_data;

   logic [3:0]  inj [NVEC];
   int unsigned checks = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   eco_equiv_sweeper dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .a_o            (a_o),
      .b_o            (b_o),
      .y_impl_i       (y_impl),
      .y_gold_i       (y_gold),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_cnt        (err_cnt),
      .diff_mask      (diff_mask),
      .first_fail_vld (first_fail_vld),
      .first_fail_vec (first_fail_vec),
      .log_rd         (log_rd),
      .log_vld        (log_vld),
      .log_data       (log_data),
      .log_ovf        (log_ovf)
   );

   // Golden netlist stand-in; the patched one differs by the injected table.
   always_comb begin
      y_gold = 4'(a_o + b_o) ^ {b_o[0], a_o[3:1]};
      y_impl = y_gold ^ inj[{b_o, a_o}];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model(input int unsigned last, output int unsigned ec, output logic [3:0] dm,
                        output bit ffv, output logic [7:0] ffvec);
      ec = 0; dm = '0; ffv = 0; ffvec = '0;
      for (int unsigned v = 0; v <= last; v++) begin
         if (inj[v] != 4'h0) begin
            ec++;
            dm |= inj[v];
            if (!ffv) begin
               ffv = 1;
               ffvec = 8'(v);
            end
         end
      end
   endtask

   task automatic clear_inj();
      for (int unsigned v = 0; v < NVEC; v++) inj[v] = 4'h0;
   endtask

   task automatic rand_inj(input int unsigned dens);
      for (int unsigned v = 0; v < NVEC; v++)
         inj[v] = ($urandom_range(0, 15) < dens) ? 4'($urandom) : 4'h0;
   endtask

   task automatic run_sweep(input string tag, input bit poke_start);
      int unsigned n;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      n = 1;
      #1 start = 1'b0;
      chk({tag, ":busy_at_start"}, 32'(busy), 32'd1);
      chk({tag, ":err_cleared"}, 32'(err_cnt), 32'd0);
      while (done !== 1'b1 && n < 2000) begin
         start = (poke_start && n == 50);
         @(posedge clk);
         n++;
         #1;
      end
      start = 1'b0;
      chk({tag, ":cycles"}, n, 32'd769);
   endtask

   task automatic check_done(input string tag);
      int unsigned ec;
      logic [3:0]  dm;
      bit          ffv;
      logic [7:0]  ffvec;
      model(NVEC - 1, ec, dm, ffv, ffvec);
      chk({tag, ":err_cnt"}, 32'(err_cnt), ec);
      chk({tag, ":diff_mask"}, 32'(diff_mask), 32'(dm));
      chk({tag, ":ff_vld"}, 32'(first_fail_vld), 32'(ffv));
      chk({tag, ":ff_vec"}, 32'(first_fail_vec), 32'(ffvec));
      chk({tag, ":pass"}, 32'(pass), 32'(ec == 0));
      chk({tag, ":busy"}, 32'(busy), 32'd0);
      chk({tag, ":ab_hold"}, 32'({b_o, a_o}), 32'hFF);
   endtask

   task automatic wait_vec(input logic [7:0] v);
      bit found = 0;
      for (int i = 0; i < 1500 && !found; i++) begin
         @(negedge clk);
         if (busy && {b_o, a_o} == v) found = 1;
      end
      chk("wait_vec", 32'(found), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ":ab"}, 32'({b_o, a_o}), 32'd0);
      chk({tag, ":flags"}, 32'({busy, done, pass, first_fail_vld, log_vld, log_ovf}), 32'd0);
      chk({tag, ":err_cnt"}, 32'(err_cnt), 32'd0);
      chk({tag, ":diff_mask"}, 32'(diff_mask), 32'd0);
      chk({tag, ":ff_vec"}, 32'(first_fail_vec), 32'd0);
      chk({tag, ":log_data"}, 32'(log_data), 32'd0);
   endtask

   initial begin
      int unsigned ec;
      logic [3:0]  dm;
      bit          ffv;
      logic [7:0]  ffvec;

      rst = 1'b1; start = 1'b0; abort = 1'b0; log_rd = 1'b0;
      clear_inj();
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) rst = 1'b0;

      // Equivalent netlists, with a start pulse mid-sweep that must be ignored.
      run_sweep("equiv", 1'b1);
      check_done("equiv");
      @(negedge clk) abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      chk("abort_in_done", 32'({busy, done}), 32'b01);

      for (int unsigned v = 0; v < NVEC; v++) inj[v] = 4'b0010;
      run_sweep("bit1", 1'b0);
      check_done("bit1");
`ifndef ECO_FAIL_LOG_EN
      chk("nolog_tied", 32'({log_vld, log_ovf, log_data}), 32'd0);
`endif

      clear_inj();
      inj[8'h53] = 4'b0001;
      run_sweep("single", 1'b0);
      check_done("single");
`ifdef ECO_FAIL_LOG_EN
      chk("single:log_vld", 32'(log_vld), 32'd1);
      chk("single:log_data", 32'(log_data), 32'h531);
      @(negedge clk) log_rd = 1'b1;
      @(posedge clk);
      #1 log_rd = 1'b0;
      chk("single:log_empty", 32'(log_vld), 32'd0);
`endif

      for (int r = 0; r < 3; r++) begin
         rand_inj($urandom_range(0, 6));
         run_sweep($sformatf("rand%0d", r), 1'b0);
         check_done($sformatf("rand%0d", r));
      end

      // Abort while vector 10 is settling, then relaunch.
      rand_inj(4);
      inj[3] = 4'h8;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_vec(8'd10);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      model(9, ec, dm, ffv, ffvec);
      chk("abort:busy_done", 32'({busy, done}), 32'b00);
      chk("abort:err_kept", 32'(err_cnt), ec);
      chk("abort:mask_kept", 32'(diff_mask), 32'(dm));
      chk("abort:ab_hold", 32'({b_o, a_o}), 32'd10);
      @(negedge clk) begin start = 1'b1; abort = 1'b1; end
      @(posedge clk);
      #1 begin start = 1'b0; abort = 1'b0; end
      chk("start_abort:idle", 32'(busy), 32'd0);
      run_sweep("after_abort", 1'b0);
      check_done("after_abort");

      // Asynchronous reset in the middle of vector 100.
      rand_inj(5);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_vec(8'd100);
      #2 rst = 1'b1;
      #1 check_all_zero("midrst");
      @(negedge clk) rst = 1'b0;
      run_sweep("after_rst", 1'b0);
      check_done("after_rst");

`ifdef ECO_FAIL_LOG_EN
      // Five mismatches into a four-deep log with no reads.
      clear_inj();
      for (int unsigned k = 0; k < 5; k++)
         inj[k * 50 + $urandom_range(0, 49)] = 4'($urandom_range(1, 15));
      run_sweep("log", 1'b0);
      check_done("log");
      chk("log:ovf", 32'(log_ovf), 32'd1);
      begin
         int unsigned seen = 0;
         for (int unsigned v = 0; v < NVEC && seen < 4; v++) begin
            if (inj[v] != 4'h0) begin
               @(negedge clk);
               chk($sformatf("log:vld%0d", seen), 32'(log_vld), 32'd1);
               chk($sformatf("log:entry%0d", seen), 32'(log_data), 32'({8'(v), inj[v]}));
               log_rd = 1'b1;
               @(posedge clk);
               #1 log_rd = 1'b0;
               seen++;
            end
         end
      end
      chk("log:drained", 32'(log_vld), 32'd0);
      clear_inj();
      run_sweep("log_clear", 1'b0);
      chk("log:ovf_cleared", 32'(log_ovf), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/eco_equiv_sweeper.md
Name: eco_equiv_sweeper

Overview:
Sequential equivalence-sweep harness for the small combinational ECO test netlists (4-bit a/b in, 4-bit y out).
- Upstream side: drives every (a,b) input vector exhaustively into two instances, the ECO-patched netlist and the golden netlist.
- Downstream side: compares their y outputs and accumulates mismatch statistics.
- Results report whether an ECO patch is equivalent and which output bits still differ.

Parameters:
- W, 4, width of each operand a and b; sweep covers 2^(2W) vectors.
- YW, 4, width of the compared output y.
- SETTLE, 1, cycles (>=0) held after driving a vector before sampling y.
- LOG_DEPTH, 4, fail-log entries (power of two, >=2); used only with ECO_FAIL_LOG_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; launches a sweep from IDLE or DONE.
- abort  in  1  pulse; stops a running sweep.
- a_o  out  W  operand a to both netlists.
- b_o  out  W  operand b to both netlists.
- y_impl_i  in  YW  y from the ECO-patched netlist.
- y_gold_i  in  YW  y from the golden netlist.
- busy  out  1  sweep in progress.
- done  out  1  sweep completed (level).
- pass  out  1  done && err_cnt==0.
- err_cnt  out  2W+1  number of mismatching vectors.
- diff_mask  out  YW  OR of all y_impl^y_gold seen.
- first_fail_vld  out  1  at least one mismatch captured.
- first_fail_vec  out  2W  {b,a} of the first mismatch.
- log_rd  in  1  pop request for the fail log.
- log_vld  out  1  log not empty.
- log_data  out  2W+YW  {b,a,diff} at the log head.
- log_ovf  out  1  sticky: a mismatch was dropped because the log was full.

Behaviour:
- Reset (async, rst=1): state IDLE, vec=0. All outputs 0: a_o, b_o, busy, done, pass, err_cnt, diff_mask, first_fail_vld, first_fail_vec, log_vld, log_data, log_ovf. Log emptied.
- States: IDLE, DRIVE, SETTLE, COMPARE, DONE.
- IDLE/DONE + start: go to DRIVE. Clear vec, err_cnt, diff_mask, first_fail_*, log and log_ovf. done=0, busy=1.
- start while busy is ignored.
- DRIVE (1 cycle): a_o=vec[W-1:0], b_o=vec[2W-1:W], registered. Next state is SETTLE if SETTLE>0, else COMPARE.
- SETTLE: counts SETTLE cycles, then goes to COMPARE.
- COMPARE (1 cycle): diff = y_impl_i ^ y_gold_i. If diff!=0:
  - err_cnt += 1;
  - diff_mask |= diff;
  - if !first_fail_vld: first_fail_vec=vec, first_fail_vld=1.
- After COMPARE: if vec == 2^(2W)-1, go to DONE (busy=0, done=1); else vec+=1 and go to DRIVE.
- Timing: per vector SETTLE+2 cycles. done rises 2^(2W)*(SETTLE+2)+1 cycles after the cycle start is sampled. Defaults: 769.
- err_cnt width 2W+1 holds the full 2^(2W) count without saturation. vec wrap never occurs.
- a_o/b_o hold the last vector in DONE and IDLE.
- abort while busy: next state IDLE, busy=0, done=0. Accumulated results are retained.
- abort in IDLE/DONE: no effect.
- start and abort in the same cycle: abort wins.
- pass is combinational from done and err_cnt.
- Reset mid-sweep clears everything immediately; no partial result survives.

Optional Feature:
Macro ECO_FAIL_LOG_EN.
- Defined: LOG_DEPTH-entry FIFO. Each COMPARE with diff!=0 pushes {vec,diff}.
  - Push while full drops the entry and sets log_ovf (sticky until start/rst).
  - log_rd && log_vld pops. Pop and push in the same cycle when full both succeed; no overflow.
  - log_data is registered head data, valid while log_vld.
- Not defined: ports remain. log_vld, log_data, log_ovf are tied 0 and log_rd is ignored.

Decomposition:
- Package eco_sweep_pkg:
  - state enum (IDLE, DRIVE, SETTLE, COMPARE, DONE);
  - localparams NVEC=2^(2W) and VEC_W=2W;
  - log entry struct {vec, diff}.
- Sub-module eco_fail_fifo: synchronous FIFO with push/pop/full/empty, instantiated only under ECO_FAIL_LOG_EN.

Test Plan:
- Both y inputs driven by the same model; start -> done at cycle 769, pass=1, err_cnt=0, diff_mask=4'h0, first_fail_vld=0.
- y_impl=y_gold^4'b0010 for all vectors -> err_cnt=256, diff_mask=4'b0010, first_fail_vec=8'h00, pass=0.
- Single mismatch on bit0 only at a=4'h3, b=4'h5 -> err_cnt=1, first_fail_vec=8'h53, diff_mask=4'b0001. With log: one entry 12'h531.
- abort during vector 10 -> next cycle IDLE, busy=0, done=0, err_cnt retained. Following start clears err_cnt to 0 and completes normally.
- rst asserted mid-sweep (vector 100) -> all outputs 0 asynchronously. start after release runs a full sweep to 769.
- ECO_FAIL_LOG_EN, LOG_DEPTH=4, 5 mismatches, no reads -> log_vld=1, 4 entries popped in vector order, log_ovf=1. Next start clears log_ovf.
